// File: rtl/prog_loader_if.sv
// Signal bundle between the program loader, its byte source, the program RAM
// write port and the CPU control lines.
interface prog_loader_if #(
    parameter int DW = 16,
    parameter int AW = 12
);
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_in;
    logic          byte_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          cpu_reset;
    logic          run;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        input  start, byte_valid, byte_in,
        output byte_ready, ram_we, ram_addr, ram_d, cpu_reset, run, busy, done, error
    );

    modport slave (
        output start, byte_valid, byte_in,
        input  byte_ready, ram_we, ram_addr, ram_d, cpu_reset, run, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian words into the CPU program RAM,
// holding the CPU in reset during the load and pulsing run once it is released.
module prog_loader #(
    parameter int DW    = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input logic           clk,
    input logic           reset,
    prog_loader_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, CHECK, DATA_HI, DATA_LO, WRITE, RELEASE, START, DONE, ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(DEPTH);

    state_t        state, state_n;
    logic [15:0]   len;
    logic [7:0]    hi;
    logic [AW:0]   count;
    logic [15:0]   count_inc;
    logic          accept;

    logic          byte_ready_q, byte_ready_n;
    logic          ram_we_q, ram_we_n;
    logic [AW-1:0] ram_addr_q, ram_addr_n;
    logic [DW-1:0] ram_d_q, ram_d_n;
    logic          cpu_reset_q, cpu_reset_n;
    logic          run_q, run_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          error_q, error_n;

    assign accept    = bus.byte_valid & byte_ready_q;
    assign count_inc = 16'(count) + 16'd1;

    // State and registered outputs; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byte_ready_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
            cpu_reset_q  <= 1'b1;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state        <= state_n;
            byte_ready_q <= byte_ready_n;
            ram_we_q     <= ram_we_n;
            ram_addr_q   <= ram_addr_n;
            ram_d_q      <= ram_d_n;
            cpu_reset_q  <= cpu_reset_n;
            run_q        <= run_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            error_q      <= error_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: if (bus.start) state_n = LEN_HI;
            LEN_HI:            if (accept) state_n = LEN_LO;
            LEN_LO:            if (accept) state_n = CHECK;
            CHECK:             state_n = (len == 16'd0 || {1'b0, len} > MAX_LEN) ? ERROR : DATA_HI;
            DATA_HI:           if (accept) state_n = DATA_LO;
            DATA_LO:           if (accept) state_n = WRITE;
            WRITE:             state_n = (count_inc == len) ? RELEASE : DATA_HI;
            RELEASE:           state_n = START;
            START:             state_n = DONE;
            default:           state_n = IDLE;
        endcase
    end

    always_comb begin
        byte_ready_n = state_n inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
        ram_we_n     = (state_n == WRITE);
        ram_addr_n   = ram_addr_q;
        ram_d_n      = ram_d_q;
        // The low byte is being accepted on this very edge, so take it straight from the bus.
        if (state_n == WRITE) begin
            ram_addr_n = count[AW-1:0];
            ram_d_n    = DW'({hi, bus.byte_in});
        end
        cpu_reset_n = !(state_n inside {RELEASE, START, DONE});
        run_n       = (state_n == START);
        busy_n      = !(state_n inside {IDLE, DONE, ERROR});
        done_n      = (state_n == DONE);
        error_n     = (state_n == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len   <= '0;
            hi    <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: if (bus.start) count <= '0;
                LEN_HI:            if (accept) len[15:8] <= bus.byte_in;
                LEN_LO:            if (accept) len[7:0] <= bus.byte_in;
                DATA_HI:           if (accept) hi <= bus.byte_in;
                WRITE:             count <= count + (AW+1)'(1);
                default:           ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_d      = ram_d_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.run        = run_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of loads plus hand-written stall and reset sequences,
// with RAM writes checked against a queue of expected (addr,data) pairs.
module tb_prog_loader;
    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        logic [15:0] seed;
        bit          exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    int   runs   = 0;
    int   w0, r0;
    logic cr_d1  = 1'b1;
    logic cr_d2  = 1'b1;
    logic run_d1 = 1'b0;
    wr_t  exp_q[$];
    vec_t vecs[7];

    prog_loader_if #(.DW(16), .AW(12)) bus ();

    prog_loader #(.DW(16), .AW(12), .DEPTH(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] gen(input logic [15:0] seed, input int i);
        return seed ^ 16'(i * 40503) ^ 16'(i >> 3);
    endfunction

    // One clock cycle; outputs are observed mid-cycle at the falling edge.
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (bus.ram_we === 1'b1) begin
            writes++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.ram_addr), 32'(e.addr));
                chk("write_data", 32'(bus.ram_d), 32'(e.data));
            end
        end
        if (bus.run === 1'b1) begin
            runs++;
            chk("run_after_release", 32'({bus.cpu_reset, cr_d1, cr_d2, run_d1}), 32'b0010);
        end
        cr_d2  = cr_d1;
        cr_d1  = bus.cpu_reset;
        run_d1 = bus.run;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        while (bus.byte_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
        step();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] addr, input logic [15:0] w);
        exp_q.push_back('{addr: addr, data: w});
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic start_load(input logic [15:0] len);
        w0 = writes;
        r0 = runs;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("load_busy", 32'(bus.busy), 32'd1);
        chk("load_flags", 32'({bus.done, bus.error, bus.cpu_reset}), 32'b001);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic finish_load(input bit exp_err, input int exp_writes);
        int n;
        n = 0;
        while (!(bus.done === 1'b1 || bus.error === 1'b1) && n < 60) begin
            step();
            n++;
        end
        chk("end_reached", 32'(n < 60), 32'd1);
        chk("done", 32'(bus.done), 32'(!exp_err));
        chk("error", 32'(bus.error), 32'(exp_err));
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("cpu_reset_end", 32'(bus.cpu_reset), 32'(exp_err));
        chk("byte_ready_end", 32'(bus.byte_ready), 32'd0);
        chk("write_count", 32'(writes - w0), 32'(exp_writes));
        chk("run_count", 32'(runs - r0), exp_err ? 32'd0 : 32'd1);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.byte_ready, bus.ram_we, bus.run, bus.busy,
                                 bus.done, bus.error, bus.cpu_reset}), 32'b0000001);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_data"}, 32'(bus.ram_d), 32'd0);
    endtask

    initial begin
        vecs[0] = '{len: 16'd1,    seed: 16'h1234, exp_err: 1'b0};
        vecs[1] = '{len: 16'd5,    seed: 16'hBEEF, exp_err: 1'b0};
        vecs[2] = '{len: 16'd0,    seed: 16'h0000, exp_err: 1'b1};
        vecs[3] = '{len: 16'd4097, seed: 16'h0000, exp_err: 1'b1};
        vecs[4] = '{len: 16'hFFFF, seed: 16'h0000, exp_err: 1'b1};
        vecs[5] = '{len: 16'd2,    seed: 16'h00FF, exp_err: 1'b0};
        vecs[6] = '{len: 16'd4096, seed: 16'h5A5A, exp_err: 1'b0};

        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;

        step();
        step();
        chk_reset_vals("reset_hold");
        reset = 1'b0;
        step();
        chk_reset_vals("after_reset");

        // Three-word load with the exact bytes 00 03 A0 05 10 00 F0 00.
        start_load(16'h0003);
        exp_q.push_back('{addr: 12'd0, data: 16'hA005});
        exp_q.push_back('{addr: 12'd1, data: 16'h1000});
        exp_q.push_back('{addr: 12'd2, data: 16'hF000});
        send_byte(8'hA0); send_byte(8'h05);
        send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hF0); send_byte(8'h00);
        finish_load(1'b0, 3);

        for (int v = 0; v < 7; v++) begin
            start_load(vecs[v].len);
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < int'(vecs[v].len); i++) begin
                    send_word(12'(i), gen(vecs[v].seed, i));
                end
            end
            finish_load(vecs[v].exp_err, vecs[v].exp_err ? 0 : int'(vecs[v].len));
        end

        // One-word load stalled in DATA_LO, with a start pulse that must be ignored.
        start_load(16'h0001);
        exp_q.push_back('{addr: 12'd0, data: 16'hC3A5});
        send_byte(8'hC3);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 2);
            step();
            chk("stall_ready", 32'({bus.byte_ready, bus.busy, bus.ram_we}), 32'b110);
        end
        bus.start = 1'b0;
        send_byte(8'hA5);
        finish_load(1'b0, 1);

        // Reset after the second of four words, then a clean two-word load.
        start_load(16'h0004);
        send_word(12'd0, 16'h1111);
        send_word(12'd1, 16'h2222);
        chk("pre_reset_writes", 32'(writes - w0), 32'd2);
        exp_q.delete();
        #2 reset = 1'b1;
        #1 chk_reset_vals("mid_reset");
        step();
        chk_reset_vals("mid_reset_held");
        reset = 1'b0;
        step();
        start_load(16'h0002);
        send_word(12'd0, 16'h3333);
        send_word(12'd1, 16'h4444);
        finish_load(1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
